// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: status codes, segment patterns (gfedcba, active-high), digit codes.
// No logic; pure types, constants and helpers.
// Used by both the display driver and the scan decoder.
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_BLANK   = 2'b00,
        ST_DIGIT   = 2'b01,
        ST_MINUS   = 2'b10,
        ST_INVALID = 2'b11
    } sseg_status_e;

    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_MINUS = 7'h40;
    localparam logic [6:0] PAT_BLANK = 7'h00;

    localparam logic [3:0] CODE_MINUS = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef struct packed {
        logic [3:0]   code;
        sseg_status_e status;
        logic         dp;
    } slot_t;

    // Driver-side encoder: digit code to pattern; E is minus, anything else non-decimal is blank.
    function automatic logic [6:0] sseg_encode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:       pat = PAT_0;
            4'd1:       pat = PAT_1;
            4'd2:       pat = PAT_2;
            4'd3:       pat = PAT_3;
            4'd4:       pat = PAT_4;
            4'd5:       pat = PAT_5;
            4'd6:       pat = PAT_6;
            4'd7:       pat = PAT_7;
            4'd8:       pat = PAT_8;
            4'd9:       pat = PAT_9;
            CODE_MINUS: pat = PAT_MINUS;
            default:    pat = PAT_BLANK;
        endcase
        return pat;
    endfunction

    // Decimal contribution of one slot; non-digit slots contribute nothing.
    function automatic logic [13:0] slot_weight(input slot_t s, input logic [13:0] w);
        logic [13:0] r;
        r = '0;
        if (s.status == ST_DIGIT) begin
            r = {10'd0, s.code} * w;
        end
        return r;
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Maps a 7-bit active-high gfedcba pattern to a digit code and slot status.
// Latency: combinational.
// Backpressure: none.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0]   pattern,
    output logic [3:0]   code,
    output sseg_status_e status
);

    always_comb begin
        code   = CODE_BLANK;
        status = ST_INVALID;
        case (pattern)
            PAT_0:     begin code = 4'd0;       status = ST_DIGIT; end
            PAT_1:     begin code = 4'd1;       status = ST_DIGIT; end
            PAT_2:     begin code = 4'd2;       status = ST_DIGIT; end
            PAT_3:     begin code = 4'd3;       status = ST_DIGIT; end
            PAT_4:     begin code = 4'd4;       status = ST_DIGIT; end
            PAT_5:     begin code = 4'd5;       status = ST_DIGIT; end
            PAT_6:     begin code = 4'd6;       status = ST_DIGIT; end
            PAT_7:     begin code = 4'd7;       status = ST_DIGIT; end
            PAT_8:     begin code = 4'd8;       status = ST_DIGIT; end
            PAT_9:     begin code = 4'd9;       status = ST_DIGIT; end
            PAT_MINUS: begin code = CODE_MINUS; status = ST_MINUS; end
            PAT_BLANK: begin code = CODE_BLANK; status = ST_BLANK; end
            default:   begin code = CODE_BLANK; status = ST_INVALID; end
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus and reassembles 4-digit frames.
// Latency: 2 + STABLE_CYCLES from pin to capture, publish 1 cycle after the last capture.
// Backpressure: none; outputs hold between frame_valid pulses.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int IDLE_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [7:0]  status,
    output logic [3:0]  dp,
    output logic [13:0] value,
    output logic        neg,
    output logic        frame_err,
    output logic        frame_valid,
    output logic        an_err,
    output logic        disp_off
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    logic [7:0]    seg_s1, seg_s2, seg_prev;
    logic [3:0]    an_s1, an_s2, an_prev;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          captured, captured_nxt;
    logic [3:0]    seen;
    slot_t [3:0]   slots;

    logic [2:0]    low_cnt;
    logic [1:0]    slot_idx;
    logic          one_low, multi_low, all_high, same;
    logic          capture, publish, idle_hit;

    logic [3:0]    dec_code;
    sseg_status_e  dec_status;

    logic [13:0]   value_calc;
    logic          neg_calc, err_calc;

    sseg_pattern_decode u_decode (
        .pattern (~seg_s2[6:0]),
        .code    (dec_code),
        .status  (dec_status)
    );

    always_comb begin
        low_cnt  = '0;
        slot_idx = '0;
        for (int i = 0; i < 4; i++) begin
            low_cnt = low_cnt + {2'b00, ~an_s2[i]};
            if (!an_s2[i]) begin
                slot_idx = 2'(i);
            end
        end
    end

    assign one_low   = (low_cnt == 3'd1);
    assign multi_low = (low_cnt > 3'd1);
    assign all_high  = (low_cnt == 3'd0);
    assign same      = ({an_s2, seg_s2} == {an_prev, seg_prev});

    // stab_cnt counts consecutive identical candidate samples, the first one included
    always_comb begin
        stab_nxt = '0;
        if (one_low) begin
            if (!same) begin
                stab_nxt = SW'(1);
            end else if (stab_cnt == STAB_MAX) begin
                stab_nxt = stab_cnt;
            end else begin
                stab_nxt = stab_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        idle_nxt = '0;
        if (all_high) begin
            idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
        end
    end

    assign idle_hit = (idle_nxt == IDLE_MAX);
    assign capture  = one_low && (stab_nxt == STAB_MAX) && !captured;
    assign publish  = (seen == 4'b1111);

    always_comb begin
        captured_nxt = captured;
        if (idle_hit || !one_low || !same) begin
            captured_nxt = 1'b0;
        end else if (capture) begin
            captured_nxt = 1'b1;
        end
    end

    always_comb begin
        value_calc = slot_weight(slots[3], 14'd1000) + slot_weight(slots[2], 14'd100)
                   + slot_weight(slots[1], 14'd10)   + slot_weight(slots[0], 14'd1);
        neg_calc = 1'b0;
        err_calc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg_calc = neg_calc | (slots[i].status == ST_MINUS);
            err_calc = err_calc | (slots[i].status == ST_INVALID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '1;
            seg_s2   <= '1;
            seg_prev <= '1;
            an_s1    <= '1;
            an_s2    <= '1;
            an_prev  <= '1;
            stab_cnt <= '0;
            idle_cnt <= '0;
            captured <= 1'b0;
            an_err   <= 1'b0;
            disp_off <= 1'b0;
        end else begin
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            an_s1    <= an;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
            stab_cnt <= stab_nxt;
            idle_cnt <= idle_nxt;
            captured <= captured_nxt;
            an_err   <= multi_low;
            if (idle_hit) begin
                disp_off <= 1'b1;
            end else if (one_low) begin
                disp_off <= 1'b0;
            end
        end
    end

    // Publish reads the slot registers before any same-cycle capture lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            slots       <= '0;
            digits      <= '0;
            status      <= '0;
            dp          <= '0;
            value       <= '0;
            neg         <= 1'b0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (capture) begin
                slots[slot_idx] <= '{code: dec_code, status: dec_status, dp: ~seg_s2[7]};
            end
            if (publish) begin
                seen <= capture ? (4'b0001 << slot_idx) : 4'b0000;
            end else if (idle_hit) begin
                seen <= '0;
            end else if (capture) begin
                seen <= seen | (4'b0001 << slot_idx);
            end
            if (publish) begin
                digits    <= {slots[3].code, slots[2].code, slots[1].code, slots[0].code};
                status    <= {slots[3].status, slots[2].status, slots[1].status, slots[0].status};
                dp        <= {slots[3].dp, slots[2].dp, slots[1].dp, slots[0].dp};
                value     <= value_calc;
                neg       <= neg_calc;
                frame_err <= err_calc;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: table of full-frame scans plus hand-written corner sequences.
module tb_sseg_scan_decoder;

    localparam int STABLE = 8;
    localparam int IDLE   = 1024;
    localparam int DW     = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [7:0]  status;
    logic [3:0]  dp;
    logic [13:0] value;
    logic        neg, frame_err, frame_valid, an_err, disp_off;

    sseg_scan_decoder #(.STABLE_CYCLES(STABLE), .IDLE_CYCLES(IDLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .status      (status),
        .dp          (dp),
        .value       (value),
        .neg         (neg),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .an_err      (an_err),
        .disp_off    (disp_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] pat;    // [3] = leftmost slot; bit 7 = dp, bits 6:0 = gfedcba, active-high
        logic [15:0]     digits;
        logic [7:0]      status;
        logic [3:0]      dp;
        logic [13:0]     value;
        logic            neg;
        logic            err;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int fv_cnt  = 0;
    int ae_cnt  = 0;
    logic [15:0] s_digits;
    logic [7:0]  s_status;
    logic [3:0]  s_dp;
    logic [13:0] s_value;
    logic        s_neg, s_err;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            s_digits = digits;
            s_status = status;
            s_dp     = dp;
            s_value  = value;
            s_neg    = neg;
            s_err    = frame_err;
        end
        if (an_err) ae_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] pat, input logic [15:0] d, input logic [7:0] st,
                                input logic [3:0] p, input logic [13:0] v, input logic n, input logic e);
        vec_t r;
        r.pat = pat; r.digits = d; r.status = st; r.dp = p; r.value = v; r.neg = n; r.err = e;
        return r;
    endfunction

    task automatic dwell(input int s, input logic [7:0] p, input int n);
        an  = ~(4'b0001 << s);
        seg = ~p;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [3:0][7:0] pats, input bit ghost);
        for (int s = 3; s >= 0; s--) begin
            if (ghost) dwell(s, 8'h7F, 3);
            dwell(s, pats[s], DW);
        end
    endtask

    task automatic check_frame(input string nm, input int f0, input vec_t v);
        #2;
        check({nm, " frames"}, 32'(fv_cnt - f0), 32'd1);
        check({nm, " digits"}, 32'(s_digits), 32'(v.digits));
        check({nm, " status"}, 32'(s_status), 32'(v.status));
        check({nm, " dp"},     32'(s_dp),     32'(v.dp));
        check({nm, " value"},  32'(s_value),  32'(v.value));
        check({nm, " neg"},    32'(s_neg),    32'(v.neg));
        check({nm, " err"},    32'(s_err),    32'(v.err));
    endtask

    task automatic check_zero(input string nm);
        check({nm, " digits"},   32'(digits),      32'd0);
        check({nm, " status"},   32'(status),      32'd0);
        check({nm, " dp"},       32'(dp),          32'd0);
        check({nm, " value"},    32'(value),       32'd0);
        check({nm, " neg"},      32'(neg),         32'd0);
        check({nm, " err"},      32'(frame_err),   32'd0);
        check({nm, " fvalid"},   32'(frame_valid), 32'd0);
        check({nm, " an_err"},   32'(an_err),      32'd0);
        check({nm, " disp_off"}, 32'(disp_off),    32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int f0, a0;
        vecs[0] = mk(32'h065B4F66, 16'h1234, 8'h55, 4'h0, 14'd1234, 1'b0, 1'b0);
        vecs[1] = mk(32'h400000ED, 16'hEFF5, 8'h81, 4'h1, 14'd5,    1'b1, 1'b0);
        vecs[2] = mk(32'h4000007B, 16'hEFFF, 8'h83, 4'h0, 14'd0,    1'b1, 1'b1);
        vecs[3] = mk(32'h6F7F073F, 16'h9870, 8'h55, 4'h0, 14'd9870, 1'b0, 1'b0);
        vecs[4] = mk(32'hFDEDE6CF, 16'h6543, 8'h55, 4'hF, 14'd6543, 1'b0, 1'b0);

        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            f0 = fv_cnt;
            scan(vecs[i].pat, 1'b0);
            check_frame($sformatf("vec%0d", i), f0, vecs[i]);
        end

        // Short 7F glitches before each digit must never be captured
        f0 = fv_cnt;
        scan(32'h065B4F66, 1'b1);
        check_frame("ghost", f0, vecs[0]);

        // Two-anode burst mid-frame: an_err every cycle, partial frame survives
        f0 = fv_cnt;
        a0 = ae_cnt;
        dwell(3, 8'h07, DW);
        dwell(2, 8'h6D, DW);
        an  = 4'b0011;
        seg = ~8'h06;
        repeat (10) @(negedge clk);
        #2;
        check("multi no frame", 32'(fv_cnt - f0), 32'd0);
        dwell(1, 8'h4F, DW);
        dwell(0, 8'h06, DW);
        #2;
        check("multi an_err count", 32'(ae_cnt - a0), 32'd10);
        check_frame("multi", f0, mk(32'h0, 16'h7531, 8'h55, 4'h0, 14'd7531, 1'b0, 1'b0));

        // Idle: partial frame discarded, published outputs hold, four fresh captures needed
        f0 = fv_cnt;
        dwell(3, 8'h07, DW);
        dwell(2, 8'h6D, DW);
        an  = 4'hF;
        seg = 8'hFF;
        repeat (IDLE + 1) @(negedge clk);
        #2;
        check("idle early disp_off", 32'(disp_off), 32'd0);
        @(negedge clk);
        #2;
        check("idle disp_off", 32'(disp_off), 32'd1);
        check("idle digits hold", 32'(digits), 32'h7531);
        dwell(1, 8'h66, DW);
        dwell(0, 8'h5B, DW);
        #2;
        check("idle no early frame", 32'(fv_cnt - f0), 32'd0);
        check("idle disp_off clear", 32'(disp_off), 32'd0);
        dwell(3, 8'h7F, DW);
        dwell(2, 8'h6F, DW);
        check_frame("post idle", f0, mk(32'h0, 16'h8942, 8'h55, 4'h0, 14'd8942, 1'b0, 1'b0));

        // Reset after two captures: outputs clear at once, no stale seen bits afterwards
        dwell(3, 8'h06, DW);
        dwell(2, 8'h5B, DW);
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f0 = fv_cnt;
        dwell(1, 8'h07, DW);
        dwell(0, 8'h7F, DW);
        #2;
        check("midreset no early frame", 32'(fv_cnt - f0), 32'd0);
        dwell(3, 8'h6D, DW);
        dwell(2, 8'h7D, DW);
        check_frame("after reset", f0, mk(32'h0, 16'h5678, 8'h55, 4'h0, 14'd5678, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment display driver. Samples the active-low segment/anode bus the driver produces, waits for each digit's dwell to be stable, decodes the segment pattern back to a digit code and reassembles a 4-digit frame. Frames are published with per-digit status, decimal points and a binary value. Used in loopback checking of the comparator/display path and as an input front end for boards reading another unit's display lines.

## Interface
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before a digit is captured (≥2)
- IDLE_CYCLES, 1024: cycles with all anodes high before the display is declared off
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- seg  in  8  segment bus, active-low; [0]=a … [6]=g, [7]=dp
- an  in  4  anode enables, active-low; an[i] low selects digit i (0 = rightmost)
- digits  out  16  published digit codes, 4 bits per slot, slot i at [4i+3:4i]
- status  out  8  published per-slot status, 2 bits per slot: 00 blank, 01 digit, 10 minus, 11 invalid
- dp  out  4  published decimal point per slot, active-high
- value  out  14  d3·1000+d2·100+d1·10+d0 over digit slots; blank/minus/invalid slots count 0
- neg  out  1  any published slot is minus
- frame_err  out  1  any published slot is invalid
- frame_valid  out  1  one-cycle pulse when digits/status/dp/value/neg/frame_err update
- an_err  out  1  one-cycle pulse on a synchronized sample with more than one anode low
- disp_off  out  1  level; anodes all high for ≥IDLE_CYCLES

## Operation
- Input sync: two flops on seg and an. All logic below uses the synchronized values.
- Stability: a sample is a candidate when exactly one anode is low.
  - stab_cnt increments while {an,seg} equals the previous sample, saturating at STABLE_CYCLES.
  - Any change, a zero-anode sample, or a multi-anode sample clears stab_cnt and the captured flag.
- Capture: when stab_cnt reaches STABLE_CYCLES and captured is 0, capture once and set captured. A steady pattern is not recaptured until it changes.
  - Capture writes slot[i] code, status and dp, and sets seen[i].
- Decode, active-high pattern gfedcba:
  - Digits: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, all status digit.
  - 40 → minus, code E.
  - 00 → blank, code F.
  - Anything else → invalid, code F.
  - dp is decoded independently of the pattern.
- Recapture of slot i before the frame completes: newest capture overwrites the slot; seen[i] stays set.
- Publish: the cycle after seen becomes 4'b1111, register all outputs, pulse frame_valid and clear seen.
  - value is computed from the slots being published.
  - A capture in the publish cycle goes into the next frame.
- Idle:
  - idle_cnt counts samples with all anodes high and clears on any low anode.
  - At IDLE_CYCLES, set disp_off and clear seen and captured. Published outputs hold.
  - disp_off clears on the first sample with exactly one anode low.
- Multi-anode sample: pulse an_err, no capture. seen is unchanged.
- Reset, any time (mid-frame included): synchronizers cleared to all-ones (idle bus), counters 0, seen 0, captured 0, slots 0. All outputs 0 (digits 0, status 0, value 0, frame_valid 0, an_err 0, disp_off 0). Partial frames are discarded.

## Timing
- Pin to synchronized sample: 2 cycles.
- Pin change to capture: 2 + STABLE_CYCLES cycles with stable input.
- Last capture to frame_valid: 1 cycle. value is registered at publish, with no extra latency.
- an_err: 3 cycles after the multi-anode value appears on the pins.
- disp_off asserts 2 + IDLE_CYCLES cycles after the anodes go all high.
- No handshake: a consumer must sample outputs on frame_valid. Outputs hold until the next publish.

## Structure
- Package sseg_pkg: 2-bit status enum (BLANK, DIGIT, MINUS, INVALID), segment pattern constants 0–9/minus/blank, code constants E/F. Shared with the display driver.
- Sub-module sseg_pattern_decode: combinational, 7-bit pattern → {code, status}.
- Everything else (synchronizer, stability counter, slots, publish, idle, value arithmetic) stays in the top.

## Test plan
- **Steady scan of "1234":** an 0111/1011/1101/1110 with patterns 06/5B/4F/66 (active-low seg inverted), 20 cycles each → frame_valid, digits 0x1234, status 0x55, value 1234, neg 0, frame_err 0.
- **Ghosting:** 3-cycle glitch pattern 7F between digits, STABLE_CYCLES = 8 → no capture of 8; frame still 0x1234.
- **"-  5":**
  - Slots: 3 = minus (40), 2 and 1 = blank, 0 = 5 with dp → status 0x81, neg 1, value 5, dp 4'b0001.
  - Slot 0 = 0x5B|0x20 (invalid) → frame_err 1, code F.
- **Multi-anode and idle:**
  - an = 0011 for 10 cycles → an_err pulses every cycle, no capture.
  - an = 1111 for IDLE_CYCLES → disp_off 1 and seen cleared.
  - The next scan needs four fresh captures before publishing.
- **Reset mid-frame:** rst_n low after 2 of 4 captures → all outputs 0 immediately. After release, a full 4-digit scan publishes exactly one frame, with no stale slots.
